ocm_s2_stream_reader: RTL and testbench

//  Fabric-side master for the 128-bit on-chip memory s2 port of soc_system. On a start command it reads
//  a block of words the HPS deposited in on-chip RAM and emits them as a valid/ready stream to fabric logic.

---
 rtl/ocm_s2_stream_reader.sv | 207 ++++++++++++++++++++
 tb/tb_ocm_s2_stream_reader.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ocm_s2_stream_reader.sv
// ocm_s2_stream_reader
//   Fabric-side read master for the 128-bit on-chip memory s2 port. When it gets a start command,
//   it reads num_words words beginning at base_addr. The word address wraps modulo 64. The words
//   are sent out as a valid/ready stream through a small output FIFO. The port is only ever read.
//
// Ports
//   clk_clk, reset_reset_n      clock, asynchronous active-low reset
//   start, base_addr, num_words job command (start is sampled only in idle)
//   abort                       synchronous cancel of the running job
//   busy, done                  job status; done pulses once when the last word is accepted
//   ocm_*                       s2 master pins (readdata has 1-cycle latency after chipselect)
//   st_data/st_valid/st_ready/st_last  output stream
//   xsum                        XOR of every accepted stream word since the last start
//
// Configuration
//   OCM_XOR_CHECKSUM_EN  when defined, xsum is a live checksum register; otherwise xsum is tied to 0.

module ocm_s2_stream_reader #(
    parameter int unsigned ADDR_W     = 6,
    parameter int unsigned DATA_W     = 128,
    parameter int unsigned BE_W       = 16,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              clk_clk,
    input  logic              reset_reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   num_words,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] ocm_address,
    output logic              ocm_chipselect,
    output logic              ocm_clken,
    output logic              ocm_write,
    output logic [DATA_W-1:0] ocm_writedata,
    output logic [BE_W-1:0]   ocm_byteenable,
    input  logic [DATA_W-1:0] ocm_readdata,
    output logic [DATA_W-1:0] st_data,
    output logic              st_valid,
    input  logic              st_ready,
    output logic              st_last,
    output logic [DATA_W-1:0] xsum
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

    state_e            state_q;
    logic [ADDR_W:0]   len_q;
    logic [ADDR_W:0]   issued_q;
    logic [ADDR_W-1:0] addr_q;
    logic              cs_q, cs_last_q;      // read presented to the RAM this cycle
    logic              pend_q, pend_last_q;  // read whose data arrives on readdata this cycle
    logic              busy_q, done_q, clken_q;

    logic [DATA_W-1:0] data_mem [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] last_mem;
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  cnt_q;

    logic              pop, abort_job, start_ok, room;
    logic [CNT_W:0]    occ;

    assign pop       = st_valid & st_ready;
    assign abort_job = abort & (state_q != StIdle);
    assign start_ok  = start & ~abort & (state_q == StIdle);

    // Stored words + both pipeline stages must fit in the FIFO. Pop is ignored here so that
    // chipselect does not depend combinationally on st_ready.
    assign occ  = {1'b0, cnt_q} + {{CNT_W{1'b0}}, pend_q} + {{CNT_W{1'b0}}, cs_q};
    assign room = occ < (CNT_W + 1)'(FIFO_DEPTH);

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q     <= StIdle;
            len_q       <= '0;
            issued_q    <= '0;
            addr_q      <= '0;
            cs_q        <= 1'b0;
            cs_last_q   <= 1'b0;
            pend_q      <= 1'b0;
            pend_last_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            clken_q     <= 1'b0;
        end else begin
            clken_q     <= 1'b1;
            done_q      <= 1'b0;
            pend_q      <= cs_q & ~abort_job;  // an in-flight read is dropped on abort
            pend_last_q <= cs_last_q;
            if (abort_job) begin
                state_q <= StIdle;
                cs_q    <= 1'b0;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    StIdle: begin
                        cs_q <= 1'b0;
                        if (start_ok) begin
                            if (num_words != '0) begin
                                len_q     <= num_words;
                                addr_q    <= base_addr;
                                issued_q  <= (ADDR_W + 1)'(1);
                                cs_q      <= 1'b1;
                                cs_last_q <= (num_words == (ADDR_W + 1)'(1));
                                busy_q    <= 1'b1;
                                state_q   <= StRun;
                            end else begin
                                done_q <= 1'b1;
                            end
                        end
                    end
                    StRun: begin
                        if (issued_q == len_q) begin
                            cs_q    <= 1'b0;
                            state_q <= StDrain;
                        end else if (room) begin
                            cs_q      <= 1'b1;
                            addr_q    <= addr_q + ADDR_W'(1);
                            issued_q  <= issued_q + (ADDR_W + 1)'(1);
                            cs_last_q <= (issued_q + (ADDR_W + 1)'(1) == len_q);
                        end else begin
                            cs_q <= 1'b0;
                        end
                    end
                    StDrain: begin
                        cs_q <= 1'b0;
                        if (pop && st_last) begin
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= StIdle;
                        end
                    end
                    default: begin
                        cs_q    <= 1'b0;
                        state_q <= StIdle;
                    end
                endcase
            end
        end
    end

    // Output FIFO; readdata is written exactly one cycle after its chipselect.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            last_mem <= '0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                data_mem[i] <= '0;
            end
        end else if (abort_job) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (pend_q) begin
                data_mem[wr_ptr_q] <= ocm_readdata;
                last_mem[wr_ptr_q] <= pend_last_q;
                wr_ptr_q           <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            if (pend_q && !pop) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end else if (!pend_q && pop) begin
                cnt_q <= cnt_q - CNT_W'(1);
            end
        end
    end

`ifdef OCM_XOR_CHECKSUM_EN
    logic [DATA_W-1:0] xsum_q;

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            xsum_q <= '0;
        end else if (start_ok) begin
            xsum_q <= '0;
        end else if (pop) begin
            xsum_q <= xsum_q ^ st_data;
        end
    end

    assign xsum = xsum_q;
`else
    assign xsum = '0;
`endif

    assign busy           = busy_q;
    assign done           = done_q;
    assign ocm_address    = addr_q;
    assign ocm_chipselect = cs_q;
    assign ocm_clken      = clken_q;
    assign ocm_write      = 1'b0;
    assign ocm_writedata  = '0;
    assign ocm_byteenable = '1;
    assign st_valid       = (cnt_q != '0);
    assign st_data        = data_mem[rd_ptr_q];
    assign st_last        = st_valid & last_mem[rd_ptr_q];

endmodule

// File: tb/tb_ocm_s2_stream_reader.sv
module tb_ocm_s2_stream_reader;

    localparam int ADDR_W = 6;
    localparam int DATA_W = 128;
    localparam int BE_W   = 16;
`ifdef OCM_XOR_CHECKSUM_EN
    localparam bit XS = 1'b1;
`else
    localparam bit XS = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start, abort, st_ready;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W:0]   num_words;
    logic              busy, done, ocm_chipselect, ocm_clken, ocm_write, st_valid, st_last;
    logic [ADDR_W-1:0] ocm_address;
    logic [DATA_W-1:0] ocm_writedata, ocm_readdata, st_data, xsum;
    logic [BE_W-1:0]   ocm_byteenable;

    always #5 clk = ~clk;

    ocm_s2_stream_reader dut (
        .clk_clk        (clk),
        .reset_reset_n  (rst_n),
        .start          (start),
        .base_addr      (base_addr),
        .num_words      (num_words),
        .abort          (abort),
        .busy           (busy),
        .done           (done),
        .ocm_address    (ocm_address),
        .ocm_chipselect (ocm_chipselect),
        .ocm_clken      (ocm_clken),
        .ocm_write      (ocm_write),
        .ocm_writedata  (ocm_writedata),
        .ocm_byteenable (ocm_byteenable),
        .ocm_readdata   (ocm_readdata),
        .st_data        (st_data),
        .st_valid       (st_valid),
        .st_ready       (st_ready),
        .st_last        (st_last),
        .xsum           (xsum)
    );

    // On-chip RAM model, read latency 1.
    logic [DATA_W-1:0] ram [64];
    always @(posedge clk) if (ocm_chipselect && ocm_clken) ocm_readdata <= ram[ocm_address];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [DATA_W:0]   exp_q [$];  // {last, data}
    logic [ADDR_W-1:0] addr_q [$];
    int n_vec = 0, n_err = 0;
    int pops = 0, reads = 0, done_cnt = 0, max_out = 0, t0 = 0;
    logic busy_seen = 1'b0, ready_toggle = 1'b0;

    task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic flag(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: got event expected none", name);
    endtask

    // Monitor / scoreboard.
    initial begin : monitor
        logic [DATA_W:0]   e;
        logic [DATA_W-1:0] held;
        logic              stalled;
        stalled = 1'b0;
        held    = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stalled = 1'b0;
            end else begin
                if (busy) busy_seen = 1'b1;
                if (done) done_cnt++;
                if (ocm_chipselect) begin
                    reads++;
                    if (addr_q.size() == 0) flag("unexpected_read");
                    else chk("read_addr", DATA_W'(ocm_address), DATA_W'(addr_q.pop_front()));
                end
                if (reads - pops > max_out) max_out = reads - pops;
                if (stalled && st_valid) chk("hold_data", st_data, held);
                if (st_valid && st_ready) begin
                    pops++;
                    if (exp_q.size() == 0) flag("unexpected_word");
                    else begin
                        e = exp_q.pop_front();
                        chk("st_data", st_data, e[DATA_W-1:0]);
                        chk("st_last", DATA_W'(st_last), DATA_W'(e[DATA_W]));
                    end
                end
                stalled = st_valid && !st_ready;
                held    = st_data;
            end
        end
    end

    initial begin : ready_drv
        forever begin
            @(posedge clk);
            #1;
            if (ready_toggle) st_ready = ~st_ready;
        end
    end

    task automatic clr_counts();
        reads = 0; pops = 0; max_out = 0; busy_seen = 1'b0;
    endtask

    task automatic go(input int b, input int n, input bit auto_exp);
        if (auto_exp) begin
            for (int k = 0; k < n; k++) begin
                exp_q.push_back({(k == n - 1), DATA_W'((b + k) % 64)});
                addr_q.push_back(ADDR_W'((b + k) % 64));
            end
        end
        @(posedge clk);
        #1;
        base_addr = ADDR_W'(b);
        num_words = (ADDR_W + 1)'(n);
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        t0    = cyc;
    endtask

    task automatic wait_done(output int first_v, output int done_at);
        first_v = -1;
        done_at = -1;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (st_valid && first_v < 0) first_v = cyc - t0;
            if (done) begin
                done_at = cyc - t0;
                break;
            end
        end
        if (done_at < 0) flag("done_timeout");
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(posedge clk);
        #1;
    endtask

    initial begin : stim
        int fv, da, dc;
        for (int i = 0; i < 64; i++) ram[i] = DATA_W'(i);
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; st_ready = 1'b1;
        base_addr = '0; num_words = '0;
        #12;
        chk("rst_busy", DATA_W'(busy), 0);
        chk("rst_done", DATA_W'(done), 0);
        chk("rst_cs", DATA_W'(ocm_chipselect), 0);
        chk("rst_clken", DATA_W'(ocm_clken), 0);
        chk("rst_valid", DATA_W'(st_valid), 0);
        chk("rst_be", DATA_W'(ocm_byteenable), DATA_W'(16'hFFFF));
        chk("rst_wr", DATA_W'(ocm_write), 0);
        chk("rst_xsum", xsum, 0);
        rst_n = 1'b1;
        idle(2);
        chk("clken_on", DATA_W'(ocm_clken), 1);

        // base 0, len 4, sink always ready.
        clr_counts(); dc = done_cnt;
        go(0, 4, 1'b1);
        wait_done(fv, da);
        chk("first_valid_lat", fv, 2);
        chk("done_lat", da, 6);
        idle(3);
        chk("a_done_once", done_cnt - dc, 1);
        chk("a_drained", exp_q.size() + addr_q.size(), 0);
        chk("a_busy_low", DATA_W'(busy), 0);
        chk("a_xsum", xsum, XS ? DATA_W'(0) : DATA_W'(0));

        // Address wrap 62,63,0,1.
        clr_counts(); dc = done_cnt;
        go(62, 4, 1'b1);
        wait_done(fv, da);
        idle(3);
        chk("wrap_done_once", done_cnt - dc, 1);
        chk("wrap_drained", exp_q.size() + addr_q.size(), 0);

        // Full 64-word job with a toggling sink: FIFO must fill and throttle reads.
        clr_counts(); dc = done_cnt;
        go(0, 64, 1'b1);
        ready_toggle = 1'b1;
        wait_done(fv, da);
        ready_toggle = 1'b0;
        st_ready     = 1'b1;
        idle(3);
        chk("full_done_once", done_cnt - dc, 1);
        chk("full_drained", exp_q.size() + addr_q.size(), 0);
        chk("full_max_outstanding", max_out, 4);

        // Zero-length job: done only.
        clr_counts(); dc = done_cnt;
        go(0, 0, 1'b0);
        wait_done(fv, da);
        chk("zero_done_lat", da, 0);
        idle(3);
        chk("zero_done_once", done_cnt - dc, 1);
        chk("zero_busy_never", DATA_W'(busy_seen), 0);

        // abort together with start in idle: start is not taken.
        clr_counts(); dc = done_cnt;
        base_addr = 6'd0; num_words = 7'd3; start = 1'b1; abort = 1'b1;
        idle(1);
        start = 1'b0; abort = 1'b0;
        idle(4);
        chk("abort_start_busy", DATA_W'(busy_seen), 0);
        chk("abort_start_done", done_cnt - dc, 0);

        // Abort after two words of a 10-word job.
        clr_counts(); dc = done_cnt;
        go(10, 10, 1'b1);
        for (int i = 0; i < 50 && pops < 2; i++) idle(1);
        abort    = 1'b1;
        st_ready = 1'b0;
        idle(1);
        abort = 1'b0;
        @(negedge clk);
        chk("abort_busy", DATA_W'(busy), 0);
        chk("abort_valid", DATA_W'(st_valid), 0);
        chk("abort_cs", DATA_W'(ocm_chipselect), 0);
        chk("abort_words", pops, 2);
        exp_q.delete();
        addr_q.delete();
        st_ready = 1'b1;
        idle(4);
        chk("abort_no_done", done_cnt - dc, 0);

        // Clean job afterwards: 5^6^7 = 4.
        clr_counts(); dc = done_cnt;
        go(5, 3, 1'b1);
        wait_done(fv, da);
        idle(3);
        chk("post_abort_done", done_cnt - dc, 1);
        chk("post_abort_drained", exp_q.size() + addr_q.size(), 0);
        chk("xsum_567", xsum, XS ? DATA_W'(4) : DATA_W'(0));

        // Checksum pattern A5/5A/FF cancels to zero.
        ram[0] = {16{8'hA5}}; ram[1] = {16{8'h5A}}; ram[2] = {16{8'hFF}};
        exp_q.push_back({1'b0, {16{8'hA5}}});
        exp_q.push_back({1'b0, {16{8'h5A}}});
        exp_q.push_back({1'b1, {16{8'hFF}}});
        for (int k = 0; k < 3; k++) addr_q.push_back(ADDR_W'(k));
        clr_counts(); dc = done_cnt;
        go(0, 3, 1'b0);
        wait_done(fv, da);
        idle(3);
        chk("cks_done", done_cnt - dc, 1);
        chk("cks_xsum", xsum, DATA_W'(0));

        // Reset in the middle of a job.
        clr_counts(); dc = done_cnt;
        go(20, 8, 1'b1);
        idle(3);
        rst_n = 1'b0;
        #1;
        chk("mrst_busy", DATA_W'(busy), 0);
        chk("mrst_valid", DATA_W'(st_valid), 0);
        chk("mrst_cs", DATA_W'(ocm_chipselect), 0);
        chk("mrst_done", DATA_W'(done), 0);
        exp_q.delete();
        addr_q.delete();
        idle(1);
        rst_n = 1'b1;
        idle(4);
        chk("mrst_no_done", done_cnt - dc, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
